// File: rtl/sync_pattern_serializer.sv
// Purpose : serialises parallel payload words into frames of
//           {sync pattern, payload MSB first, guard zeros}.
// Latency : first sync bit appears on stream_out 1 cycle after the accept edge.
// Backpr. : in_ready only while idle; at least one idle cycle separates frames.
// Ports   : clk/rst (async, active-high); in_valid/in_ready/in_data word handshake;
//           stream_out serial bit; busy, sync_done, frame_done status pulses;
//           frame_count counts completed frames and wraps.
module sync_pattern_serializer #(
  parameter int                  DATA_WIDTH   = 8,
  parameter int                  SYNC_LEN     = 5,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 5'b11010,
  parameter int                  GUARD_BITS   = 1,
  parameter int                  CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  stream_out,
  output logic                  busy,
  output logic                  sync_done,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  // Bit counter must index the longest of the three frame sections.
  localparam int MAXL1 = (SYNC_LEN > DATA_WIDTH) ? SYNC_LEN : DATA_WIDTH;
  localparam int MAXL  = (MAXL1 > GUARD_BITS) ? MAXL1 : GUARD_BITS;
  localparam int CW    = (MAXL > 1) ? $clog2(MAXL + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GUARD} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;       // index of the bit currently on stream_out
  logic [SYNC_LEN-1:0]   r_sync;      // remaining sync bits, next one at MSB
  logic [DATA_WIDTH-1:0] r_shift;     // remaining payload bits, next one at MSB
  logic                  r_stream;
  logic                  r_busy;
  logic                  r_sync_done;
  logic                  r_frame_done;
  logic [CNT_WIDTH-1:0]  r_frame_count;

  logic w_accept;

  assign in_ready    = (r_state == S_IDLE);
  assign w_accept    = in_valid && in_ready;
  assign stream_out  = r_stream;
  assign busy        = r_busy;
  assign sync_done   = r_sync_done;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

  // Every output register is loaded with the value of the bit that will be on
  // the wire during the next cycle, so pulses line up with stream_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sync        <= '0;
      r_shift       <= '0;
      r_stream      <= 1'b0;
      r_busy        <= 1'b0;
      r_sync_done   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      // frame_done marks the final frame bit; the count moves as it ends.
      if (r_frame_done) r_frame_count <= r_frame_count + CNT_WIDTH'(1);

      case (r_state)
        S_IDLE: begin
          r_stream     <= 1'b0;
          r_busy       <= 1'b0;
          r_sync_done  <= 1'b0;
          r_frame_done <= 1'b0;
          if (w_accept) begin
            r_state     <= S_SYNC;
            r_cnt       <= '0;
            r_shift     <= in_data;
            r_stream    <= SYNC_PATTERN[SYNC_LEN-1];
            r_sync      <= SYNC_PATTERN << 1;
            r_busy      <= 1'b1;
            r_sync_done <= (SYNC_LEN == 1);
          end
        end

        S_SYNC: begin
          if (int'(r_cnt) == SYNC_LEN - 1) begin
            r_state      <= S_DATA;
            r_cnt        <= '0;
            r_stream     <= r_shift[DATA_WIDTH-1];
            r_shift      <= r_shift << 1;
            r_sync_done  <= 1'b0;
            r_frame_done <= (DATA_WIDTH == 1) && (GUARD_BITS == 0);
          end else begin
            r_cnt       <= r_cnt + CW'(1);
            r_stream    <= r_sync[SYNC_LEN-1];
            r_sync      <= r_sync << 1;
            r_sync_done <= (int'(r_cnt) + 1 == SYNC_LEN - 1);
          end
        end

        S_DATA: begin
          if (int'(r_cnt) == DATA_WIDTH - 1) begin
            r_cnt    <= '0;
            r_stream <= 1'b0;
            if (GUARD_BITS > 0) begin
              r_state      <= S_GUARD;
              r_frame_done <= (GUARD_BITS == 1);
            end else begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b0;
            end
          end else begin
            r_cnt        <= r_cnt + CW'(1);
            r_stream     <= r_shift[DATA_WIDTH-1];
            r_shift      <= r_shift << 1;
            r_frame_done <= (GUARD_BITS == 0) && (int'(r_cnt) + 1 == DATA_WIDTH - 1);
          end
        end

        S_GUARD: begin
          r_stream <= 1'b0;
          if (int'(r_cnt) == GUARD_BITS - 1) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
          end else begin
            r_cnt        <= r_cnt + CW'(1);
            r_frame_done <= (int'(r_cnt) + 1 == GUARD_BITS - 1);
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_stream <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sync_pattern_serializer.md
Name: sync_pattern_serializer

Overview:
- Transmit-side companion of the serial 11010 pattern detector (`pattern_detector`).
- Accepts parallel payload words over a valid/ready handshake.
- Emits each word as a serial frame: sync pattern (default 11010, MSB first), then payload MSB first, then guard zeros.
- Drives the single-bit stream that the detector consumes; also reports frame progress and a frame counter.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (>=1).
- SYNC_LEN, 5, sync pattern length in bits (>=1).
- SYNC_PATTERN, 5'b11010, sync bits; bit SYNC_LEN-1 is sent first.
- GUARD_BITS, 1, zero bits appended after payload (>=0).
- CNT_WIDTH, 16, width of frame_count.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, payload word offered.
- in_data, input, DATA_WIDTH, payload word; sampled only on an accept.
- in_ready, output, 1, block can accept a word this cycle.
- stream_out, output, 1, serial bit stream, registered.
- busy, output, 1, a frame is being transmitted.
- sync_done, output, 1, one-cycle pulse while stream_out carries the last sync bit.
- frame_done, output, 1, one-cycle pulse while stream_out carries the last bit of the frame.
- frame_count, output, CNT_WIDTH, count of completed frames; wraps.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; stream_out=0, busy=0, sync_done=0, frame_done=0, frame_count=0.
  - in_ready=1 once rst deasserts.
  - Any in-flight frame is discarded. It is not resumed after reset.
- States: IDLE, SYNC, DATA, GUARD. A bit counter and a shift register hold position and payload.
- IDLE:
  - in_ready=1, stream_out=0, busy=0.
  - Accept = in_valid && in_ready at a rising edge. On accept, in_data is latched into the shift register and the state goes to SYNC.
  - in_data changes after the accept have no effect on the frame.
- SYNC:
  - Outputs SYNC_PATTERN bits, MSB first, one per cycle, for SYNC_LEN cycles.
  - The first sync bit appears on stream_out in the cycle after the accept edge (latency 1).
  - sync_done=1 during the last sync bit. Then go to DATA.
- DATA:
  - Outputs payload bits MSB first, DATA_WIDTH cycles.
  - After the last payload bit: go to GUARD if GUARD_BITS>0, else to IDLE.
- GUARD:
  - stream_out=0 for GUARD_BITS cycles, then IDLE.
- Frame length: exactly SYNC_LEN+DATA_WIDTH+GUARD_BITS cycles of busy=1.
- frame_done:
  - High during the final frame bit: the last guard bit, or the last payload bit when GUARD_BITS=0.
  - frame_count increments at the edge ending that cycle.
  - Wraps from 2^CNT_WIDTH-1 to 0.
- in_ready=0 whenever busy=1. in_valid during busy is ignored (no accept, no latch).
- Inter-frame gap: at least one IDLE cycle (stream_out=0) between frames, even with in_valid held high continuously.
- stream_out, busy, sync_done and frame_done are all registered; no combinational path from inputs to them.
- The payload is not bit-stuffed. A payload containing the sync pattern can alias at the receiver; that is the system's responsibility.
- SYNC_LEN=1, DATA_WIDTH=1 and GUARD_BITS=0 must all work.

Test Plan:
- Reset, then hold idle 10 cycles with in_valid=0:
  - Required: stream_out=0, busy=0, in_ready=1, frame_count=0 throughout.
- Accept in_data=8'hA5 (defaults):
  - stream_out over the next 14 cycles = 1,1,0,1,0 then 1,0,1,0,0,1,0,1 then 0.
  - sync_done in cycle 5; frame_done in cycle 14; frame_count=1; in_ready=0 during cycles 1–14.
- in_valid held high with words 8'h00, 8'hFF, 8'h3C:
  - Three frames of 14 bits each, each separated by exactly one idle 0 cycle.
  - Payloads emitted in order; frame_count=3.
  - Toggling in_data mid-frame does not alter the serial bits.
- Loopback into `pattern_detector`, payload 8'h00:
  - pattern_found pulses exactly once per frame, in the cycle after sync_done.
  - For 4 frames: 4 pulses.
- Assert rst asynchronously in cycle 8 of a frame (mid-payload):
  - stream_out, busy and frame_count go to 0 immediately, without waiting for a clock edge.
  - After release, the next accepted word produces a complete, correct frame.
- Parameter variant SYNC_LEN=1, SYNC_PATTERN=1'b1, DATA_WIDTH=1, GUARD_BITS=0, with frame_count preloaded near wrap by running 65535 frames (or CNT_WIDTH=2, 4 frames):
  - Each frame is 2 bits.
  - frame_count wraps to 0 on the overflowing frame.
